// File: rtl/fpu_mantissa_mul_arbiter.sv
// Round-robin sharing of one mantissa multiplier core between FP-mul (req 0) and div/sqrt (req 1).
// Define MUL_ARB_STATS_EN to add saturating grant/conflict counters (stat_grant0/1, stat_conflict).
module fpu_mantissa_mul_arbiter #(
   parameter int BIT_LENGTH = 24,
   parameter int MUL_LAT    = 1,
   parameter int TAG_W      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [2*BIT_LENGTH-1:0] req_man_x,
   input  logic [2*BIT_LENGTH-1:0] req_man_y,
   input  logic [2*TAG_W-1:0]      req_tag,
   output logic [1:0]              resp_valid,
   input  logic [1:0]              resp_ready,
   output logic [2*BIT_LENGTH-1:0] resp_result,
   output logic [1:0]              resp_redund,
   output logic [2*TAG_W-1:0]      resp_tag,
   output logic [BIT_LENGTH-1:0]   mul_man_x,
   output logic [BIT_LENGTH-1:0]   mul_man_y,
   input  logic [BIT_LENGTH-1:0]   mul_result,
   input  logic                    mul_redundant
`ifdef MUL_ARB_STATS_EN
   ,
   output logic [15:0]             stat_grant0,
   output logic [15:0]             stat_grant1,
   output logic [15:0]             stat_conflict
`endif
);

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_BUSY = 2'd1,
      SLOT_DONE = 2'd2
   } slot_e;

   slot_e                    slot_r [2];
   logic                     rr_ptr_r;
   logic [1:0]               eligible_s;
   logic [1:0]               grant_s;
   logic [1:0]               exit_hit_s;
   logic [1:0]               accept_s;
   logic                     issue_s;
   logic                     issue_id_s;
   logic [BIT_LENGTH-1:0]    sel_x_s;
   logic [BIT_LENGTH-1:0]    sel_y_s;
   logic [TAG_W-1:0]         sel_tag_s;
   logic [BIT_LENGTH-1:0]    mul_x_r;
   logic [BIT_LENGTH-1:0]    mul_y_r;
   logic [MUL_LAT-1:0]       pipe_v_r;
   logic [MUL_LAT-1:0]       pipe_id_r;
   logic [TAG_W-1:0]         pipe_tag_r [MUL_LAT];
   logic [1:0]               resp_valid_r;
   logic [2*BIT_LENGTH-1:0]  resp_result_r;
   logic [1:0]               resp_redund_r;
   logic [2*TAG_W-1:0]       resp_tag_r;

   // Eligibility and round-robin grant; a slot holding a result is never eligible
   always_comb begin
      eligible_s = 2'b00;
      grant_s    = 2'b00;
      for (int i = 0; i < 2; i++) begin
         eligible_s[i] = req_valid[i] && (slot_r[i] == SLOT_IDLE);
      end
      case (eligible_s)
         2'b01:   grant_s = 2'b01;
         2'b10:   grant_s = 2'b10;
         2'b11:   grant_s = rr_ptr_r ? 2'b10 : 2'b01;
         default: grant_s = 2'b00;
      endcase
   end

   // Operand and tag selection for the granted requester
   always_comb begin
      sel_x_s   = {BIT_LENGTH{1'b0}};
      sel_y_s   = {BIT_LENGTH{1'b0}};
      sel_tag_s = {TAG_W{1'b0}};
      if (grant_s[1]) begin
         sel_x_s   = req_man_x[2*BIT_LENGTH-1:BIT_LENGTH];
         sel_y_s   = req_man_y[2*BIT_LENGTH-1:BIT_LENGTH];
         sel_tag_s = req_tag[2*TAG_W-1:TAG_W];
      end else begin
         sel_x_s   = req_man_x[BIT_LENGTH-1:0];
         sel_y_s   = req_man_y[BIT_LENGTH-1:0];
         sel_tag_s = req_tag[TAG_W-1:0];
      end
   end

   // Decode which slot (if any) the oldest pipe entry belongs to
   always_comb begin
      exit_hit_s = 2'b00;
      if (pipe_v_r[MUL_LAT-1]) begin
         exit_hit_s = pipe_id_r[MUL_LAT-1] ? 2'b10 : 2'b01;
      end else begin
         exit_hit_s = 2'b00;
      end
   end

   assign issue_s    = |grant_s;
   assign issue_id_s = grant_s[1];
   assign accept_s   = resp_valid_r & resp_ready;

   // Operand registers, round-robin pointer and the latency-matching pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r  <= 1'b0;
         mul_x_r   <= {BIT_LENGTH{1'b0}};
         mul_y_r   <= {BIT_LENGTH{1'b0}};
         pipe_v_r  <= {MUL_LAT{1'b0}};
         pipe_id_r <= {MUL_LAT{1'b0}};
         for (int k = 0; k < MUL_LAT; k++) begin
            pipe_tag_r[k] <= {TAG_W{1'b0}};
         end
      end else begin
         if (issue_s) begin
            rr_ptr_r <= grant_s[0];
            mul_x_r  <= sel_x_s;
            mul_y_r  <= sel_y_s;
         end
         pipe_v_r[0]   <= issue_s;
         pipe_id_r[0]  <= issue_id_s;
         pipe_tag_r[0] <= sel_tag_s;
         for (int k = 1; k < MUL_LAT; k++) begin
            pipe_v_r[k]   <= pipe_v_r[k-1];
            pipe_id_r[k]  <= pipe_id_r[k-1];
            pipe_tag_r[k] <= pipe_tag_r[k-1];
         end
      end
   end

   // Per-requester slot FSM with the response holding registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            slot_r[i] <= SLOT_IDLE;
         end
         resp_valid_r  <= 2'b00;
         resp_result_r <= {(2*BIT_LENGTH){1'b0}};
         resp_redund_r <= 2'b00;
         resp_tag_r    <= {(2*TAG_W){1'b0}};
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (slot_r[i])
               SLOT_IDLE: begin
                  if (grant_s[i]) begin
                     slot_r[i] <= SLOT_BUSY;
                  end
               end
               SLOT_BUSY: begin
                  if (exit_hit_s[i]) begin
                     slot_r[i]                                  <= SLOT_DONE;
                     resp_valid_r[i]                            <= 1'b1;
                     resp_result_r[i*BIT_LENGTH +: BIT_LENGTH]  <= mul_result;
                     resp_redund_r[i]                           <= mul_redundant;
                     resp_tag_r[i*TAG_W +: TAG_W]               <= pipe_tag_r[MUL_LAT-1];
                  end
               end
               SLOT_DONE: begin
                  if (accept_s[i]) begin
                     slot_r[i]       <= SLOT_IDLE;
                     resp_valid_r[i] <= 1'b0;
                  end
               end
               default: begin
                  slot_r[i]       <= SLOT_IDLE;
                  resp_valid_r[i] <= 1'b0;
               end
            endcase
         end
      end
   end

   assign req_ready   = grant_s;
   assign resp_valid  = resp_valid_r;
   assign resp_result = resp_result_r;
   assign resp_redund = resp_redund_r;
   assign resp_tag    = resp_tag_r;
   assign mul_man_x   = mul_x_r;
   assign mul_man_y   = mul_y_r;

`ifdef MUL_ARB_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      if (v == 16'hffff) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

   logic [15:0] stat_grant0_r;
   logic [15:0] stat_grant1_r;
   logic [15:0] stat_conflict_r;

   // Saturating grant and contention counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grant0_r   <= 16'd0;
         stat_grant1_r   <= 16'd0;
         stat_conflict_r <= 16'd0;
      end else begin
         if (grant_s[0]) begin
            stat_grant0_r <= sat_inc(stat_grant0_r);
         end
         if (grant_s[1]) begin
            stat_grant1_r <= sat_inc(stat_grant1_r);
         end
         if (&eligible_s) begin
            stat_conflict_r <= sat_inc(stat_conflict_r);
         end
      end
   end

   assign stat_grant0   = stat_grant0_r;
   assign stat_grant1   = stat_grant1_r;
   assign stat_conflict = stat_conflict_r;
`endif

endmodule
